// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
// Size codes, FSM states and the access legality rule live here so top and aligner agree.
package data_ram_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_IDLE  = 2'b01,
    ST_RBUSY = 2'b10
  } state_e;

  // Illegal when the access is wider than a word or not naturally aligned.
  function automatic logic access_illegal(input logic [1:0] size,
                                          input int unsigned offset,
                                          input int unsigned nb);
    int unsigned nbytes;
    nbytes = 32'd1 << size;
    return (nbytes > nb) || ((offset & (nbytes - 32'd1)) != 32'd0);
  endfunction

endpackage

// File: rtl/ram_load_align.sv
// Load aligner: shifts the addressed lanes down to bit 0 and sign/zero extends
// them to the full word width.
module ram_load_align
  import data_ram_pkg::*;
#(
  parameter  int DataWidth = 32,
  localparam int OB        = $clog2(DataWidth / 8)
) (
  input  logic [DataWidth-1:0] word_i,
  input  logic [OB-1:0]        off_i,
  input  size_e                size_i,
  input  logic                 unsigned_i,
  output logic [DataWidth-1:0] data_o
);

  logic [DataWidth-1:0] shifted;
  int                   nbits;
  logic                 sbit;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    nbits   = 8 << size_i;
    if (nbits > DataWidth) nbits = DataWidth;
    sbit = 1'b0;
    for (int i = 0; i < DataWidth; i++) begin
      if (i == nbits - 1) sbit = shifted[i];
    end
    for (int i = 0; i < DataWidth; i++) begin
      data_o[i] = (i < nbits) ? shifted[i] : (sbit & ~unsigned_i);
    end
  end

endmodule

// File: rtl/data_ram.sv
// Synchronous single-port data memory with byte/half/word access, alignment
// checking, configurable read latency and a post-reset clear sweep.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 32,
  parameter int DataDepth    = 256,
  parameter int Latency      = 1,
  parameter int ClearOnReset = 1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Req,
  input  logic                 W,
  input  logic [1:0]           Size,
  input  logic                 Unsigned,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] W_data,
  output logic                 Ready,
  output logic                 R_valid,
  output logic [DataWidth-1:0] R_data,
  output logic                 Err
);

  localparam int NB = DataWidth / 8;
  localparam int OB = $clog2(NB);
  localparam int IB = $clog2(DataDepth);

  logic [DataWidth-1:0] mem_q [DataDepth];

  state_e               state_q, state_d;
  logic [IB-1:0]        clr_idx_q, clr_idx_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 ready_q, r_valid_q, err_q;
  logic [DataWidth-1:0] r_data_q;

  logic [DataWidth-1:0] rd_word_q;
  logic [OB-1:0]        rd_off_q;
  size_e                rd_size_q;
  logic                 rd_uns_q, rd_ill_q;

  logic [IB-1:0]        req_idx;
  logic [OB-1:0]        req_off;
  logic                 req_ill;
  logic                 accept_rd, accept_wr, expire, clr_we, wr_en;
  logic [NB-1:0]        wmask;
  logic [DataWidth-1:0] wdata_sh;
  logic [DataWidth-1:0] aligned;
  logic                 unused_addr;

  // Upper address bits are ignored so accesses wrap modulo the array size.
  assign req_idx     = Addr[OB+IB-1:OB];
  assign req_off     = Addr[OB-1:0];
  assign unused_addr = ^Addr[AddrWidth-1:OB+IB];
  assign req_ill     = access_illegal(Size, 32'(req_off), NB);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= (ClearOnReset != 0) ? ST_CLEAR : ST_IDLE;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == ST_IDLE);
      r_valid_q <= expire;
      err_q     <= (accept_wr & req_ill) | (expire & rd_ill_q);
      if (expire) r_data_q <= rd_ill_q ? '0 : aligned;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (ClearOnReset == 0 || clr_idx_q == IB'(DataDepth - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept_rd) begin
          state_d = ST_RBUSY;
          cnt_d   = 2'(Latency - 1);
        end
      end
      ST_RBUSY: begin
        if (cnt_q == 2'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_rd = Req & ready_q & ~W;
    accept_wr = Req & ready_q & W;
    expire    = (state_q == ST_RBUSY) && (cnt_q == 2'd0);
    clr_we    = (state_q == ST_CLEAR);
    wr_en     = accept_wr & ~req_ill;
    wdata_sh  = W_data << {req_off, 3'b000};
    wmask     = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[b] = (b >= int'(req_off)) && (b < int'(req_off) + (1 << Size));
    end
  end

  // The sweep owns the write port while clearing; requests are blocked then.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem_q[req_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept_rd) begin
      rd_word_q <= mem_q[req_idx];
      rd_off_q  <= req_off;
      rd_size_q <= size_e'(Size);
      rd_uns_q  <= Unsigned;
      rd_ill_q  <= req_ill;
    end
  end

  ram_load_align #(.DataWidth(DataWidth)) u_align (
    .word_i    (rd_word_q),
    .off_i     (rd_off_q),
    .size_i    (rd_size_q),
    .unsigned_i(rd_uns_q),
    .data_o    (aligned)
  );

  assign Ready   = ready_q;
  assign R_valid = r_valid_q;
  assign R_data  = r_data_q;
  assign Err     = err_q;

endmodule

// File: doc/data_ram.md
# data_ram

Synchronous, parametrised data memory for the MIPS datapath MEM stage. It succeeds the flat combinational word RAM with a clocked single-port array, byte/halfword/word access with sign or zero extension, alignment checking, configurable read latency with a ready/valid handshake, and a hardware clear sweep after reset. One request is in flight at a time; the pipeline stalls on `Ready` low.

## Interface
Parameters:
- `DataWidth`, 32: word width; multiple of 8, power of two; lanes `NB = DataWidth/8`, offset bits `OB = clog2(NB)`.
- `AddrWidth`, 32: byte-address width.
- `DataDepth`, 256: words; power of two; index bits `IB = clog2(DataDepth)`.
- `Latency`, 1: read latency in cycles, 1..4.
- `ClearOnReset`, 1: 1 = zero the whole array after reset release; 0 = skip the sweep.

Ports:
- `CLK` in 1: clock, rising edge.
- `RSTn` in 1: reset, asynchronous, active-low.
- `Req` in 1: request valid.
- `W` in 1: 1 = write, 0 = read.
- `Size` in 2: access size of `1<<Size` bytes (00 byte, 01 half, 10 word, 11 dword).
- `Unsigned` in 1: read extension, 1 = zero-extend, 0 = sign-extend.
- `Addr` in AddrWidth: byte address.
- `W_data` in DataWidth: store data, right-justified.
- `Ready` out 1: can accept a request this cycle.
- `R_valid` out 1: one-cycle pulse; `R_data` is valid.
- `R_data` out DataWidth: extended load result; holds its value between pulses.
- `Err` out 1: one-cycle pulse flagging an illegal access.

## Operation
- State machine `CLEAR` / `IDLE` / `RBUSY`. Reset enters `CLEAR` when `ClearOnReset=1`, otherwise `IDLE`.
- `CLEAR`
  - Writes zero to index 0..DataDepth-1, one word per cycle.
  - Moves to `IDLE` after the last index.
  - `Req` is ignored.
- Acceptance: a request is accepted at a rising edge where `Req & Ready` is high.
- Word index is `Addr[OB+IB-1:OB]`. Higher address bits are ignored, so addresses wrap modulo `DataDepth*NB`.
- An access is illegal when either of these holds:
  - `(1<<Size) > NB`;
  - `Addr[OB-1:0]` is not a multiple of `1<<Size`.
- Write, in `IDLE`
  - Updates only the byte lanes `Addr[OB-1:0]` .. `+(1<<Size)-1` with the low bytes of `W_data`.
  - An illegal write leaves memory unchanged and pulses `Err`.
  - State stays `IDLE`.
- Read, in `IDLE`: moves to `RBUSY`, loads a down-counter with `Latency-1`, and captures index, lane offset, `Size` and `Unsigned`.
- On counter expiry:
  - `R_data` is the selected lanes shifted to bit 0, then extended (sign or zero) to DataWidth.
  - `R_valid` pulses and the state returns to `IDLE`.
  - An illegal read returns `R_data = 0` with `R_valid` and `Err` pulsing together.
- Reset asserted mid-operation: the FSM, counter and outputs clear immediately. A pending read is dropped (no `R_valid`). The array is re-zeroed on release only if `ClearOnReset=1`.

## Timing
- Reset values: `Ready=0`, `R_valid=0`, `R_data=0`, `Err=0`.
- Clear sweep:
  - `Ready` rises after exactly `DataDepth` edges following reset release.
  - With `ClearOnReset=0`, `Ready` rises after the first edge.
- Read
  - Accepted at edge t0; `Ready` is low from t0.
  - `R_valid`, `R_data` and `Ready` all become high at edge t0+Latency.
  - The earliest next acceptance is edge t0+Latency+1, so sustained read throughput is one per `Latency+1` cycles.
- Write
  - Memory is updated at acceptance edge t0; `Ready` stays high, so back-to-back writes are allowed.
  - `Err` for an illegal write asserts at t0 for one cycle.
- Read-after-write: a read accepted at t0+1 returns data written at t0.

## Structure
- Package `data_ram_pkg` holds:
  - the `Size` encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`);
  - the FSM state enum;
  - the legality function `(size, offset, NB) -> illegal`.
- Sub-module `ram_load_align`: combinational lane select plus sign/zero extension, parametrised on `DataWidth`.
- The top level holds the array, FSM, clear counter, latency counter and write-lane mask.

## Test plan
- Reset release with `DataDepth=256`, `ClearOnReset=1` -> `Ready` low for 256 cycles, then high; a word read of `Addr=0x3FC` returns `0x00000000`.
- Word write `0x8899AABB` to `0x10`, then byte write `0x7F` to `0x11` -> word read returns `0x88997FBB`; signed byte read of `0x13` returns `0xFFFFFF88`; unsigned returns `0x00000088`.
- `Latency=3`: read accepted at edge 0 -> `R_valid` and `Ready` high at edge 3 only; a `Req` held high is next accepted at edge 4.
- Half write to `0x21` -> `Err` pulse and memory unchanged; word read of `0x22` -> `R_valid` and `Err` together with `R_data=0`.
- Write `0x12345678` to `0x400` with `DataDepth=256` -> word read of `0x000` returns `0x12345678` (wrap).
- `RSTn` pulsed low during `RBUSY` -> no `R_valid`; all outputs are 0 while in reset.
